// File: rtl/halton_pkg.sv
// Shared types and constant helpers for the base-[2,3] Halton index decoder.
// Pure compile-time content: no logic, no latency.
package halton_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [63:0] pow3(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd3;
    return p;
  endfunction

  // Accumulator must hold 3^SCALE_1-1; counter must reach SCALE_1.
  function automatic int acc_width(input int s1);
    return $clog2(pow3(s1));
  endfunction

  function automatic int cnt_width(input int s1);
    return $clog2(s1 + 1);
  endfunction

  localparam int SCALE_1_DEFAULT = 7;
  localparam int ACC_W_DEFAULT   = acc_width(SCALE_1_DEFAULT);
  localparam int CNT_W_DEFAULT   = cnt_width(SCALE_1_DEFAULT);

endpackage

// File: rtl/halton_b3_digit_reverse.sv
// Serial base-3 digit reversal: peels one digit of w per cycle into acc, SCALE_1 cycles.
// done_o pulses one cycle after the last digit; start_i restarts unconditionally, no backpressure.
module halton_b3_digit_reverse
  import halton_pkg::*;
#(
  parameter int SCALE_1 = 7,
  localparam int ACC_W = acc_width(SCALE_1),
  localparam int CNT_W = cnt_width(SCALE_1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [31:0]      w_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             done_o
);

  logic [31:0]      w_q, w_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       digit;

  always_comb begin
    digit  = 2'(w_q % 32'd3);
    w_d    = w_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      w_d    = w_i;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = acc_q * ACC_W'(3) + ACC_W'(digit);
      w_d   = w_q / 32'd3;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(SCALE_1 - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      w_q    <= w_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign acc_o  = acc_q;
  assign done_o = done_q;

endmodule

// File: rtl/halton_index_decoder.sv
// Recovers k mod 2^SCALE_0 / k mod 3^SCALE_1 from a Halton pair and checks it against a tracked index.
// Result SCALE_1+1 cycles after acceptance; one pair in flight, in_ready low until the result is taken.
module halton_index_decoder
  import halton_pkg::*;
#(
  parameter int SCALE_0 = 11,
  parameter int SCALE_1 = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] halton_in_0,
  input  logic [31:0] halton_in_1,
  input  logic [31:0] seed,
  input  logic        reseed_enable,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] index_0,
  output logic [31:0] index_1,
  output logic        range_err,
  output logic        mismatch
);

  localparam int          ACC_W   = acc_width(SCALE_1);
  localparam logic [31:0] POW3    = 32'(pow3(SCALE_1));
  localparam logic [32:0] POW3_33 = 33'(pow3(SCALE_1));

  state_t             state_q, state_d;
  logic [SCALE_0-1:0] h0_rev;
  logic [SCALE_0-1:0] index_0_q, index_0_d;
  logic [SCALE_0-1:0] exp_0_q, exp_0_d;
  logic [ACC_W-1:0]   index_1_q, index_1_d;
  logic [ACC_W-1:0]   exp_1_q, exp_1_d;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   reseed_1;
  logic               range_q, range_d;
  logic               in_range_err;
  logic               start;
  logic               dec_done;
  logic [32:0]        seed_p1;

  halton_b3_digit_reverse #(
    .SCALE_1 (SCALE_1)
  ) u_b3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .w_i     (halton_in_1),
    .acc_o   (acc),
    .done_o  (dec_done)
  );

  // 33-bit sum so seed=FFFFFFFF reduces to 2^32 mod POW3 rather than wrapping.
  assign seed_p1      = {1'b0, seed} + 33'd1;
  assign reseed_1     = ACC_W'(seed_p1 % POW3_33);
  assign in_range_err = ((halton_in_0 >> SCALE_0) != 32'd0) || (halton_in_1 >= POW3);

  always_comb begin
    h0_rev = '0;
    for (int i = 0; i < SCALE_0; i++) h0_rev[i] = halton_in_0[SCALE_0-1-i];
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          start   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: if (dec_done) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    index_0_d = index_0_q;
    index_1_d = index_1_q;
    range_d   = range_q;
    exp_0_d   = exp_0_q;
    exp_1_d   = exp_1_q;
    if (start) begin
      range_d   = in_range_err;
      index_0_d = in_range_err ? '0 : h0_rev;
    end
    if (dec_done) index_1_d = range_q ? '0 : acc;
    // A reseed overrides the post-handshake increment in the same cycle.
    if (reseed_enable) begin
      exp_0_d = seed_p1[SCALE_0-1:0];
      exp_1_d = reseed_1;
    end else if (state_q == DONE && out_ready) begin
      exp_0_d = exp_0_q + SCALE_0'(1);
      exp_1_d = (exp_1_q == ACC_W'(POW3 - 32'd1)) ? '0 : exp_1_q + ACC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      index_0_q <= '0;
      index_1_q <= '0;
      range_q   <= 1'b0;
      exp_0_q   <= SCALE_0'(1);
      exp_1_q   <= ACC_W'(1);
    end else begin
      state_q   <= state_d;
      index_0_q <= index_0_d;
      index_1_q <= index_1_d;
      range_q   <= range_d;
      exp_0_q   <= exp_0_d;
      exp_1_q   <= exp_1_d;
    end
  end

  assign index_0   = 32'(index_0_q);
  assign index_1   = 32'(index_1_q);
  assign range_err = range_q;
  assign mismatch  = (state_q == DONE) && !range_q &&
                     ((index_0_q != exp_0_q) || (index_1_q != exp_1_q));

endmodule

// File: tb/tb_halton_index_decoder.sv
// Randomized and directed check of halton_index_decoder against an index-level reference model.
module tb_halton_index_decoder;

  localparam int     S0 = 11;
  localparam int     S1 = 7;
  localparam longint M0 = 64'd2048;
  localparam longint P3 = 64'd2187;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] halton_in_0;
  logic [31:0] halton_in_1;
  logic [31:0] seed;
  logic        reseed_enable;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] index_0;
  logic [31:0] index_1;
  logic        range_err;
  logic        mismatch;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint e;  // expected sequence index the DUT should be tracking

  always #5 clk = ~clk;

  halton_index_decoder #(.SCALE_0(S0), .SCALE_1(S1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .halton_in_0   (halton_in_0),
    .halton_in_1   (halton_in_1),
    .seed          (seed),
    .reseed_enable (reseed_enable),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .index_0       (index_0),
    .index_1       (index_1),
    .range_err     (range_err),
    .mismatch      (mismatch)
  );

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic longint p3(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 3;
    return p;
  endfunction

  // Generator-side encoding of index k.
  function automatic logic [31:0] enc0(input longint k);
    logic [31:0] r = '0;
    for (int i = 0; i < S0; i++)
      if (((k >> i) & 64'd1) != 0) r = r | (32'd1 << (S0 - 1 - i));
    return r;
  endfunction

  function automatic logic [31:0] enc1(input longint k);
    longint kk = k;
    longint r  = 0;
    for (int i = 0; i < S1; i++) begin
      r  = r + (kk % 3) * p3(S1 - 1 - i);
      kk = kk / 3;
    end
    return 32'(r);
  endfunction

  // mode: 0 plain, 1 reseed during decode, 2 reseed on the result handshake.
  task automatic run_pair(input logic [31:0] h0, input logic [31:0] h1,
                          input longint ei0, input longint ei1, input bit erng,
                          input int stall, input int mode, input logic [31:0] rs_seed);
    int n;
    bit emm;
    out_ready   = (stall == 0);
    halton_in_0 = h0;
    halton_in_1 = h1;
    in_valid    = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    check_eq("accept_rdy", longint'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
      if (mode == 1 && n == 2) begin reseed_enable = 1'b1; seed = rs_seed; end
      if (mode == 1 && n == 3) begin reseed_enable = 1'b0; e = longint'(rs_seed) + 1; end
    end
    check_eq("latency", n, S1 + 1);
    emm = !erng && ((ei0 != e % M0) || (ei1 != e % P3));
    check_eq("index_0", longint'(index_0), ei0);
    check_eq("index_1", longint'(index_1), ei1);
    check_eq("range_err", longint'(range_err), longint'(erng));
    check_eq("mismatch", longint'(mismatch), longint'(emm));
    for (int s = 0; s < stall; s++) begin
      in_valid    = 1'b1;
      halton_in_0 = $urandom;
      halton_in_1 = $urandom;
      @(posedge clk); #1;
      check_eq("stall_ov", longint'(out_valid), 1);
      check_eq("stall_rdy", longint'(in_ready), 0);
      check_eq("stall_idx0", longint'(index_0), ei0);
      check_eq("stall_idx1", longint'(index_1), ei1);
      check_eq("stall_mm", longint'(mismatch), longint'(emm));
    end
    in_valid = 1'b0;
    if (mode == 2) begin reseed_enable = 1'b1; seed = rs_seed; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    reseed_enable = 1'b0;
    check_eq("ret_idle", longint'({out_valid, in_ready}), 1);
    if (mode == 2) e = longint'(rs_seed) + 1;
    else           e = e + 1;
  endtask

  task automatic send_k(input longint k, input int stall, input int mode, input logic [31:0] s);
    run_pair(enc0(k), enc1(k), k % M0, k % P3, 1'b0, stall, mode, s);
  endtask

  task automatic reseed_idle(input logic [31:0] s);
    reseed_enable = 1'b1;
    seed          = s;
    @(posedge clk); #1;
    reseed_enable = 1'b0;
    e = longint'(s) + 1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     ov_seen;
    longint k;
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    reseed_enable = 1'b0;
    seed          = '0;
    halton_in_0   = '0;
    halton_in_1   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", longint'(in_ready), 1);
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_index_0", longint'(index_0), 0);
    check_eq("rst_index_1", longint'(index_1), 0);
    check_eq("rst_range_err", longint'(range_err), 0);
    check_eq("rst_mismatch", longint'(mismatch), 0);
    rst_n = 1'b1;
    e = 1;
    @(posedge clk); #1;

    send_k(1, 0, 0, 0);
    for (int i = 2; i <= 5; i++) send_k(i, 0, 0, 0);

    reseed_idle(32'd5);
    send_k(6, 0, 0, 0);
    send_k(2, 0, 0, 0);                        // expected index is 7 here
    run_pair(32'd0, 32'd2187, 0, 0, 1'b1, 0, 0, 0);
    send_k(e, 0, 0, 0);                        // expected index advanced past the range error
    send_k(e, 5, 0, 0);
    send_k(100, 0, 1, 32'd99);
    send_k(e, 0, 2, 32'd499);
    send_k(500, 0, 0, 0);

    reseed_idle(32'hFFFF_FFFF);
    send_k(e, 0, 0, 0);

    reseed_idle(32'd2185);
    send_k(2186, 0, 0, 0);
    send_k(2187, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      int stall, mode;
      stall = $urandom_range(0, 2);
      mode  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      if ($urandom_range(0, 7) == 0)
        run_pair(32'(2048 + $urandom_range(0, 5000)), 32'($urandom_range(0, 2186)),
                 0, 0, 1'b1, stall, mode, $urandom);
      else begin
        k = ($urandom_range(0, 1) == 1) ? e : longint'($urandom_range(0, 200000));
        send_k(k, stall, mode, 32'($urandom_range(0, 100000)));
      end
    end

    halton_in_0 = enc0(e);
    halton_in_1 = enc1(e);
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", longint'(out_valid), 0);
    check_eq("midrst_index_0", longint'(index_0), 0);
    check_eq("midrst_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ov_seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    check_eq("midrst_no_result", ov_seen, 0);
    e = 1;
    send_k(1, 0, 0, 0);
    send_k(2, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
